// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding unit and the EXE-stage operand muxes.
package hazard_forward_ctrl_pkg;

    // EXE operand mux selects.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // SRAM wait state machine encodings.
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } fsm_state_e;

    // Operand source pick: the MEM result is younger than WB, so it wins.
    function automatic logic [1:0] fwd_encode(input logic en,
                                              input logic mem_hit,
                                              input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_REG;
        if (en) begin
            if (mem_hit) begin
                sel = FWD_MEM;
            end else if (wb_hit) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_mem_wait_fsm.sv
// SRAM wait tracker: freezes the pipe while an access is outstanding and latches
// a sticky error when the SRAM fails to answer within TIMEOUT wait cycles.
module mem_wait_fsm
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_access,
    input  logic mem_ready,
    input  logic err_clr,
    output logic freeze,
    output logic timeout_err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    fsm_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;

    // State, timer and sticky flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Next-state and freeze decode; freeze acts in the same cycle the access stalls.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        freeze  = 1'b0;
        unique case (state_q)
            RUN: begin
                // A ready with no access pending is meaningless and ignored.
                if (mem_access && !mem_ready) begin
                    freeze  = 1'b1;
                    state_d = WAIT;
                    timer_d = TMR_W'(1);
                end
            end
            WAIT: begin
                freeze = !mem_ready;
                if (mem_ready) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ERROR: begin
                // Pipe stays frozen until software acknowledges the fault.
                freeze = 1'b1;
                if (err_clr) begin
                    state_d = RUN;
                    timer_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
                timer_d = '0;
            end
        endcase
    end

    assign timeout_err = err_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit beside ID: load-use / RAW stall detection, EXE forwarding selects,
// SRAM wait freeze and a saturating stall-cycle counter.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int unsigned REG_W   = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic             two_src,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             wb_wb_en,
    input  logic [REG_W-1:0] wb_dest,
    input  logic [REG_W-1:0] ex_src1,
    input  logic [REG_W-1:0] ex_src2,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    input  logic             err_clr,
    output logic             hazard,
    output logic             freeze,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout_err
);

    logic             exe_match;
    logic             mem_match;
    logic             raw;
    logic [CNT_W-1:0] count_q, count_d;

    mem_wait_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_wait_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_access (mem_access),
        .mem_ready  (mem_ready),
        .err_clr    (err_clr),
        .freeze     (freeze),
        .timeout_err(timeout_err)
    );

    // RAW detection against the ID sources; register 0 is an ordinary register.
    always_comb begin
        exe_match = (exe_dest == id_src1) | (two_src & (exe_dest == id_src2));
        mem_match = (mem_dest == id_src1) | (two_src & (mem_dest == id_src2));
        if (forward_en) begin
            // With forwarding only a load in EXE cannot be bypassed in time.
            raw = exe_wb_en & exe_mem_r_en & exe_match;
        end else begin
            raw = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
        end
        // No bubble while frozen: the pipe registers are holding anyway.
        hazard = raw & ~freeze;
    end

    // EXE operand forwarding selects.
    always_comb begin
        fwd_sel1 = fwd_encode(forward_en,
                              mem_wb_en & (mem_dest == ex_src1),
                              wb_wb_en & (wb_dest == ex_src1));
        fwd_sel2 = fwd_encode(forward_en,
                              mem_wb_en & (mem_dest == ex_src2),
                              wb_wb_en & (wb_dest == ex_src2));
    end

    // Stall counter next value: clear wins, increment saturates.
    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (hazard && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stall_count = count_q;

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Next-generation hazard unit for the 5-stage ARM-subset pipeline; sits beside the ID stage and drives the IF/ID stall, the ID/EX bubble, the whole-pipe freeze and the EXE-stage forwarding muxes.
- Adds three things to the plain stall detector:
  - a run-time forwarding mode, which stalls only on load-use;
  - an SRAM wait/timeout state machine with a sticky error flag;
  - a saturating stall-cycle performance counter.

Parameters:
REG_W, 4, register index width
CNT_W, 16, stall counter width
TIMEOUT, 64, maximum WAIT cycles before error (>=1)
TMR_W, $clog2(TIMEOUT+1), wait timer width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
forward_en  in  1  1 = forwarding mode, 0 = stall-only mode
two_src  in  1  ID instruction reads id_src2
id_src1, id_src2  in  REG_W  ID-stage source registers
exe_wb_en, exe_mem_r_en  in  1  EXE instruction writes back / is a load
exe_dest  in  REG_W  EXE destination register
mem_wb_en  in  1  MEM-stage write-back enable
mem_dest  in  REG_W  MEM-stage destination register
wb_wb_en  in  1  WB-stage write-back enable
wb_dest  in  REG_W  WB-stage destination register
ex_src1, ex_src2  in  REG_W  sources of the instruction in EXE
mem_access  in  1  MEM stage performs a load or store
mem_ready  in  1  SRAM completes the access this cycle
cnt_clr, err_clr  in  1  synchronous clears
hazard  out  1  stall PC and IF/ID; insert ID/EX bubble
freeze  out  1  hold every pipeline register
fwd_sel1, fwd_sel2  out  2  00 = regfile, 01 = MEM result, 10 = WB result
stall_count  out  CNT_W  cycles with hazard=1
timeout_err  out  1  sticky SRAM timeout flag

Behaviour:
- Source match: match(d) = (d==id_src1) | (two_src & d==id_src2).
- Raw hazard, forward_en=0: raw = (exe_wb_en & match(exe_dest)) | (mem_wb_en & match(mem_dest)).
- Raw hazard, forward_en=1: raw = exe_wb_en & exe_mem_r_en & match(exe_dest). The MEM stage never stalls in this mode.
- Output: hazard = raw & ~freeze. No bubble is inserted while frozen.
- Forwarding, per source, combinational:
  - MEM match has priority: mem_wb_en & mem_dest==ex_srcN gives 01.
  - Otherwise wb_wb_en & wb_dest==ex_srcN gives 10.
  - Otherwise 00.
  - Both selects are forced to 00 when forward_en=0.
- FSM states: RUN, WAIT, ERROR.
  - RUN: if mem_access & ~mem_ready, then freeze=1 in the same cycle, go to WAIT, timer=1. Otherwise freeze=0.
  - WAIT:
    - freeze = ~mem_ready.
    - mem_ready=1: freeze=0 that cycle, go to RUN, timer=0.
    - Otherwise timer increments. When timer==TIMEOUT and ~mem_ready: go to ERROR, set timeout_err.
  - ERROR: freeze=1 and timeout_err=1 hold until err_clr=1, then go to RUN and clear timer and timeout_err. err_clr has no effect in RUN or WAIT.
- mem_ready together with ~mem_access in RUN is ignored.
- TIMEOUT=1: ERROR is entered after a single WAIT cycle without ready.
- stall_count:
  - +1 on each cycle with hazard=1.
  - Saturates at all-ones and does not wrap.
  - cnt_clr forces 0 and wins over a simultaneous increment.
- Reset (rst=0, asynchronous):
  - Registers: state=RUN, timer=0, stall_count=0, timeout_err=0.
  - Combinational outputs follow the inputs with state=RUN.
  - Reset asserted mid-WAIT or in ERROR returns immediately to RUN with the error cleared.
- Register 0 has no special meaning: a match on index 0 is a real dependency.
- Latency: hazard, freeze and fwd_sel are combinational (zero cycle). State, timer, counter and flag update on the rising clock edge.

Decomposition:
- Shared package: fwd_sel encodings (FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and the FSM state encodings (RUN, WAIT, ERROR). The pipeline's EXE mux imports the same constants.
- One sub-module, mem_wait_fsm. It contains the FSM, timer and timeout_err, takes mem_access, mem_ready and err_clr, and outputs freeze.

Test Plan:
- forward_en=0, exe_wb_en=1, exe_dest=3, id_src1=3 -> hazard=1; same with two_src=0 and only id_src2=3 -> hazard=0.
- forward_en=1, exe_wb_en=1, exe_mem_r_en=0, exe_dest=5=id_src1 -> hazard=0. Set exe_mem_r_en=1 -> hazard=1.
- forward_en=1, mem_dest=wb_dest=7=ex_src1, both wb_en=1 -> fwd_sel1=01. Drop mem_wb_en -> fwd_sel1=10. forward_en=0 -> fwd_sel1=00.
- mem_access=1, mem_ready=0 for 3 cycles, then 1 -> freeze=1 for cycles 0-2, 0 on cycle 3; FSM back in RUN; hazard masked while frozen.
- TIMEOUT=4, mem_ready held 0 -> ERROR after 4 WAIT cycles; timeout_err=1 and freeze held. Pulse err_clr -> RUN with flag 0.
- CNT_W=2, hazard held 5 cycles -> stall_count 1,2,3,3,3. cnt_clr with hazard=1 -> 0. rst low mid-WAIT -> RUN, all counters 0.
